vtb_control: RTL
================

VTB_CONTROL -- requirements
Module: vtb_control

Interface
REQ-001 SHALL have parameter WD_FSM, default 4: width of the ACS segment index; 2^WD_FSM segments per decoded symbol.
REQ-002 SHALL have parameter WD_DEPTH, default 4: width of the survivor page index; 2^WD_DEPTH pages in survivor RAM.
REQ-003 SHALL have port CLOCK, input, 1: the single clock; all state changes on posedge CLOCK.
REQ-004 SHALL have port Reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port SymbolValid, input, 1: upstream has a branch-metric symbol ready.
REQ-006 SHALL have port SymbolReady, output, 1: one-CLOCK strobe; a symbol is accepted when SymbolValid and SymbolReady are both high.
REQ-007 SHALL have port Clock1, output, 1: CLOCK/2 phase clock for ACS and survivor writes.
REQ-008 SHALL have port Clock2, output, 1: CLOCK/4 phase clock selecting the write (low) or traceback read (high) half.
REQ-009 SHALL have port Active, output, 1: ACS/MMU enable.
REQ-010 SHALL have port Hold, output, 1: suppresses traceback read clocks.
REQ-011 SHALL have port Init, output, 1: traceback page reload request.
REQ-012 SHALL have port ACSPage, output, WD_DEPTH: survivor page currently being written.
REQ-013 SHALL have port ACSSegment, output, WD_FSM: current ACS segment.
REQ-014 SHALL have port ACSSegment_minusLSB, output, WD_FSM-1: ACSSegment without its LSB (RAM byte address).
REQ-015 SHALL have port TBValid, output, 1: survivor RAM holds a full traceback depth.

Function
REQ-016 SHALL hold a 2-bit phase counter ph, incrementing mod 4 every CLOCK while Reset is high; Clock1 = ph[0], Clock2 = ph[1], both driven from flops.
REQ-017 SHALL implement states IDLE, RUN, STALL; state changes only on the posedge at which ph==3 (the Clock2 period boundary).
REQ-018 SHALL drive Active=0, Hold=1 in IDLE and STALL; Active=1, Hold=0 in RUN.
REQ-019 SHALL assert SymbolReady for exactly one CLOCK when ph==3 and either state is IDLE/STALL or (state is RUN and ACSSegment==2^WD_FSM-1); otherwise SymbolReady=0.
REQ-020 SHALL transition IDLE->RUN and STALL->RUN on an accepted symbol; IDLE and STALL are otherwise held.
REQ-021 SHALL transition RUN->RUN on an accepted symbol at the last segment; RUN->STALL at the last segment if no symbol is accepted.
REQ-022 SHALL increment ACSSegment in RUN on each posedge where ph is 1 or 3, wrapping 2^WD_FSM-1 -> 0; one symbol occupies 2^(WD_FSM+1) CLOCKs.
REQ-023 SHALL hold ACSSegment in IDLE/STALL; ACSSegment SHALL equal 0 on the first CLOCK of RUN, with ph==0.
REQ-024 SHALL increment ACSPage mod 2^WD_DEPTH on the same edge at which ACSSegment wraps to 0, and only at that edge.
REQ-025 SHALL assert Init during the first Clock2 period (ph 0..3, segments 0 and 1) of every symbol in RUN and deassert it otherwise, so the Clock2 falling edge at the period end samples Init=1.
REQ-026 SHALL count completed symbols in a saturating counter; TBValid SHALL rise on the edge that completes the 2^WD_DEPTH-th symbol and SHALL stay high until reset.
REQ-027 SHALL treat SymbolValid dropping while SymbolReady is low as no effect; it SHALL be sampled only on SymbolReady cycles.
REQ-028 SHALL gate every output change by the phase rules above so that Clock1/Clock2 never glitch; the outputs SHALL have no combinational path from SymbolValid.

Reset
REQ-029 SHALL, on Reset low, immediately force: ph=0, Clock1=0, Clock2=0, state IDLE, Active=0, Hold=1, Init=0, SymbolReady=0, ACSPage=0, ACSSegment=0, ACSSegment_minusLSB=0, TBValid=0, symbol counter 0.
REQ-030 SHALL, on Reset asserted mid-symbol, abandon the symbol; after release it SHALL restart from IDLE with ph=0 on the first CLOCK.

Verification
REQ-031 Reset release, SymbolValid=1 constant -> SymbolReady at CLOCK 3, RUN from CLOCK 4, ACSSegment 0..15 over 32 CLOCKs, then ACSPage 0->1 with ACSSegment 0.
REQ-032 Clock check in RUN -> Clock1 period 2 CLOCKs, Clock2 period 4 CLOCKs, Init high for exactly 4 CLOCKs starting at segment 0 of each symbol.
REQ-033 SymbolValid=0 at the last segment of symbol 3 -> STALL, Active=0, Hold=1, ACSSegment holds 15, ACSPage holds; SymbolValid=1 8 CLOCKs later -> RUN at the next ph==0 with ACSSegment 0.
REQ-034 Continuous symbols -> TBValid=0 through 15 symbols, 1 when symbol 16 completes; ACSPage wraps 15->0 at the same edge.
REQ-035 Reset low at segment 9 of page 5 -> all outputs at reset values within the same cycle, no Clock1/Clock2 pulse while low; after release behaves as REQ-031.
REQ-036 ACSSegment_minusLSB equals ACSSegment[WD_FSM-1:1] at every CLOCK over a full symbol.

Source files
------------

// File: rtl/vtb_control.sv
// Viterbi decoder sequencer: phase clocks, ACS segment/page counters and traceback handshakes.
// Latency: a symbol accepted at the ph==3 edge starts RUN on the next CLOCK; each symbol takes 2^(WD_FSM+1) CLOCKs.
// Backpressure: SymbolValid is sampled only on SymbolReady strobes; without a symbol the engine parks in STALL.
module vtb_control #(
  parameter int WD_FSM   = 4,
  parameter int WD_DEPTH = 4
) (
  input  logic                CLOCK,
  input  logic                Reset,
  input  logic                SymbolValid,
  output logic                SymbolReady,
  output logic                Clock1,
  output logic                Clock2,
  output logic                Active,
  output logic                Hold,
  output logic                Init,
  output logic [WD_DEPTH-1:0] ACSPage,
  output logic [WD_FSM-1:0]   ACSSegment,
  output logic [WD_FSM-2:0]   ACSSegment_minusLSB,
  output logic                TBValid
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STALL} state_e;

  localparam logic [WD_FSM-1:0]   SEG_MAX  = {WD_FSM{1'b1}};
  localparam logic [WD_DEPTH:0]   CNT_FULL = {1'b1, {WD_DEPTH{1'b0}}};

  state_e              state_q, state_d;
  logic [1:0]          ph_q, ph_d;
  logic [WD_FSM-1:0]   seg_q, seg_d;
  logic [WD_DEPTH-1:0] page_q, page_d;
  logic [WD_DEPTH:0]   cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                init_q, init_d;
  logic                act_q, act_d;
  logic                hold_q, hold_d;
  logic                tbv_q, tbv_d;
  logic                accept;
  logic                last_seg;

  // Next-state and registered-output decode; every output is re-timed through a flop.
  always_comb begin
    ph_d     = ph_q + 2'd1;
    state_d  = state_q;
    seg_d    = seg_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    accept   = SymbolValid & rdy_q;
    last_seg = (seg_q == SEG_MAX);

    case (state_q)
      ST_RUN: begin
        if ((ph_q == 2'd3) && last_seg) begin
          // Symbol completes here, whether or not a new one follows.
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + (WD_DEPTH+1)'(1);
          if (accept) seg_d = '0;
          else        state_d = ST_STALL;
        end else if (ph_q[0]) begin
          seg_d = seg_q + WD_FSM'(1);
        end
      end
      default: begin
        // IDLE/STALL: segment parked; a symbol restarts RUN at segment 0.
        if (accept) begin
          state_d = ST_RUN;
          seg_d   = '0;
        end
      end
    endcase

    // A new survivor page starts whenever the segment rolls from last to 0.
    if (last_seg && (seg_d == '0)) page_d = page_q + WD_DEPTH'(1);

    rdy_d  = (ph_d == 2'd3) && ((state_d != ST_RUN) || (seg_d == SEG_MAX));
    init_d = (state_d == ST_RUN) && (seg_d[WD_FSM-1:1] == '0);
    act_d  = (state_d == ST_RUN);
    hold_d = (state_d != ST_RUN);
    tbv_d  = tbv_q | cnt_d[WD_DEPTH];
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ph_q    <= 2'd0;
      seg_q   <= '0;
      page_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      init_q  <= 1'b0;
      act_q   <= 1'b0;
      hold_q  <= 1'b1;
      tbv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      seg_q   <= seg_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      init_q  <= init_d;
      act_q   <= act_d;
      hold_q  <= hold_d;
      tbv_q   <= tbv_d;
    end
  end

  assign Clock1              = ph_q[0];
  assign Clock2              = ph_q[1];
  assign SymbolReady         = rdy_q;
  assign Init                = init_q;
  assign Active              = act_q;
  assign Hold                = hold_q;
  assign ACSPage             = page_q;
  assign ACSSegment          = seg_q;
  assign ACSSegment_minusLSB = seg_q[WD_FSM-1:1];
  assign TBValid             = tbv_q;

endmodule
